mem: RTL and testbench
======================

# mem

Memory-access stage of the five-stage pipeline. It consumes the 157-bit EXE->MEM bus, issues load/store transactions to data memory over a req/ack handshake, and extracts and sign- or zero-extends load data. It also forwards the write-back fields to WB. It holds the stage, via `MEM_over`, until the memory transaction completes. It tracks one instruction at a time with a small FSM, and an outstanding request can be cancelled by a pipeline flush.

## Interface
- No parameters.
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `MEM_valid`  in  1  stage holds a valid instruction
- `EXE_MEM_bus_r`  in  157  registered EXE->MEM bus, MSB first: mem_control[5:0], store_data[31:0], exe_result[31:0], lo_result[31:0], hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr[7:0], syscall, eret, rf_wen, rf_wdest[4:0], pc[31:0], break
- `MEM_WB_go`  in  1  top accepts this instruction into WB this cycle
- `cancel`  in  1  flush of this stage (exception/eret)
- `dm_req`  out  1  memory request; held until `dm_ack`
- `dm_wr`  out  1  1 = store, 0 = load
- `dm_addr`  out  32  word address, {exe_result[31:2], 2'b00}
- `dm_wstrb`  out  4  byte write strobes (0 for loads)
- `dm_wdata`  out  32  store data, lane-replicated
- `dm_ack`  in  1  transfer completes when `dm_req & dm_ack`
- `dm_rdata`  in  32  load data, valid in the ack cycle
- `MEM_over`  out  1  stage finished, may advance
- `MEM_WB_bus`  out  121  {mem_result[31:0], lo_result, hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr, syscall, eret, rf_wen, rf_wdest, pc, break, adel, ades}
- `MEM_wdest`  out  5  rf_wdest & {5{MEM_valid}}
- `MEM_pc`  out  32  pc field

## Operation
- mem_control fields:
  - [5] load
  - [4] store
  - [3:2] size: 00 byte, 01 half, 10/11 word
  - [1] sign-extend on load
  - [0] reserved, ignored
- A memop is load|store.
- FSM states and transitions:
  - IDLE: `dm_req = MEM_valid & memop & ~err & ~cancel`.
    - Request with `dm_ack` -> DONE (load data captured).
    - Request without `dm_ack` -> REQ.
  - REQ: `dm_req` = 1.
    - `dm_ack & ~cancel` -> DONE.
    - `dm_ack & cancel` -> IDLE.
    - `~dm_ack & cancel` -> DRAIN.
  - DONE: `dm_req` = 0.
    - `MEM_WB_go` or `cancel` -> IDLE.
  - DRAIN: `dm_req` = 1, `MEM_over` = 0.
    - `dm_ack` -> IDLE.
    - Further `cancel` is ignored.
- A store cancelled after issue still completes in memory. The top must not cancel a store once it has been issued.
- `MEM_over = MEM_valid & ~cancel & (~memop | err | state==DONE)`. Non-memops never leave IDLE.
- Load data is captured into `rdata_r` on `dm_req & dm_ack` for loads.
- Load extraction:
  - byte: lane addr[1:0]
  - half: lane addr[1]
  - extension per mem_control[1]
  - word: raw
- `mem_result` = extracted load value for loads; exe_result otherwise, and also on address error, so CP0 gets BadVAddr.
- Store strobes:
  - byte: 4'b0001 << addr[1:0], wdata {4{sd[7:0]}}
  - half: 4'b0011 << {addr[1],1'b0}, wdata {2{sd[15:0]}}
  - word: 4'b1111, wdata sd
- `dm_wr` = store. `dm_addr`, `dm_wstrb` and `dm_wdata` must stay stable while `dm_req` is high, because `EXE_MEM_bus_r` is held by the top while `MEM_over` = 0.

## Timing
- Reset: state IDLE, `rdata_r` = 0. While `reset` is high, `dm_req` and `MEM_over` are forced 0. All other outputs are combinational from the bus.
- Non-memop: `MEM_over` in the same cycle as `MEM_valid`.
- Memop with zero-wait ack: request cycle N, `MEM_over` at N+1.
- Memop with k wait cycles: `MEM_over` at N+1+k.
- DONE persists, with `MEM_over` = 1, until `MEM_WB_go`. The next instruction's request may start the cycle after.
- Reset mid-REQ or mid-DRAIN returns to IDLE. Memory-side recovery is the top's responsibility.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: err = (half & addr[0]) | (word & addr[1:0] != 0).
  - No request is issued.
  - adel = load & err, ades = store & err.
  - `rf_wen` on the bus is forced 0.
  - `MEM_over` is asserted immediately.
- Not defined: err = 0, adel = ades = 0. Misaligned low address bits are ignored (half uses addr[1] only, word uses the aligned word).

## Test plan
- ALU op (mem_control = 0, exe_result = 0x1234) -> `MEM_over` in the same cycle, no `dm_req`, mem_result = 0x1234.
- LB sign, addr 0x103, `dm_rdata` = 0x80FF_FF7F, ack after 2 waits -> `dm_req` held 3 cycles, `MEM_over` at cycle 4, mem_result = 0xFFFF_FF80.
- SH, addr 0x202, sd = 0xAAAA_BEEF, zero-wait ack -> `dm_wstrb` = 4'b1100, `dm_wdata` = 0xBEEF_BEEF, `dm_addr` = 0x200, DONE held until `MEM_WB_go`.
- LW with `cancel` in REQ without ack, ack 2 cycles later -> DRAIN, `dm_req` held, `MEM_over` never 1, IDLE after ack.
- With `MEM_ALIGN_CHECK_EN`: LW at addr 0x301 -> no `dm_req`, `MEM_over` immediate, adel = 1, rf_wen = 0, mem_result = 0x301. Without the macro: word read from 0x300.
- Back-to-back LW/LW, both zero-wait -> `MEM_WB_go` in DONE, second request the next cycle, both results correct.

Source files
------------

// File: rtl/mem_if.sv
// Data-memory request/acknowledge channel between the MEM stage
// and data memory.
interface mem_if;
  logic        dm_req;
  logic        dm_wr;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_wr, dm_addr,
    output dm_wstrb, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_wr, dm_addr,
    input  dm_wstrb, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem.sv
// Memory-access pipeline stage: data-memory handshake and load extraction.
// Optional misalignment exceptions: define MEM_ALIGN_CHECK_EN.
module mem (
  input  logic         clk,
  input  logic         reset,
  input  logic         MEM_valid,
  input  logic [156:0] EXE_MEM_bus_r,
  input  logic         MEM_WB_go,
  input  logic         cancel,
  mem_if.master        dm,
  output logic         MEM_over,
  output logic [120:0] MEM_WB_bus,
  output logic [4:0]   MEM_wdest,
  output logic [31:0]  MEM_pc
);

  typedef struct packed {
    logic [5:0]  mc;
    logic [31:0] sd;
    logic [31:0] res;
    logic [31:0] lo;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r;
    logic        syscall;
    logic        eret;
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] pc;
    logic        brk;
  } exe_mem_t;

  typedef enum logic [1:0] {
    IDLE, REQ, DONE, DRAIN
  } state_t;

  exe_mem_t b;
  state_t   state, state_n;

  logic        load, store, memop;
  logic        is_byte, is_half, is_word;
  logic        err, adel, ades;
  logic [1:0]  a;
  logic [31:0] rdata_r;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [31:0] shb;
  logic [15:0] hv;
  logic [31:0] ld_val;
  logic [31:0] mem_result;
  logic        req;
  logic        unused_bits;

  assign b       = EXE_MEM_bus_r;
  assign a       = b.res[1:0];
  assign load    = b.mc[5];
  assign store   = b.mc[4];
  assign memop   = load | store;
  assign is_byte = (b.mc[3:2] == 2'b00);
  assign is_half = (b.mc[3:2] == 2'b01);
  assign is_word = b.mc[3];

  assign unused_bits = b.mc[0];

`ifdef MEM_ALIGN_CHECK_EN
  assign err  = (is_half & a[0])
              | (is_word & (a != 2'b00));
  assign adel = load & err;
  assign ades = store & err;
`else
  assign err  = 1'b0;
  assign adel = 1'b0;
  assign ades = 1'b0;
`endif

  always_comb begin
    strb  = 4'b0000;
    wdata = b.sd;
    unique case (1'b1)
      is_byte: begin
        strb  = 4'b0001 << a;
        wdata = {4{b.sd[7:0]}};
      end
      is_half: begin
        strb  = 4'b0011 << {a[1], 1'b0};
        wdata = {2{b.sd[15:0]}};
      end
      is_word: strb = 4'b1111;
    endcase
  end

  assign dm.dm_wr    = store;
  assign dm.dm_addr  = {b.res[31:2], 2'b00};
  assign dm.dm_wstrb = store ? strb : 4'b0000;
  assign dm.dm_wdata = wdata;

  // Extraction runs off the captured word so DONE can wait on WB.
  assign shb = rdata_r >> {a, 3'b000};
  assign hv  = a[1] ? rdata_r[31:16]
                    : rdata_r[15:0];

  always_comb begin
    ld_val = rdata_r;
    unique case (1'b1)
      is_byte: ld_val = {{24{b.mc[1] & shb[7]}},
                         shb[7:0]};
      is_half: ld_val = {{16{b.mc[1] & hv[15]}},
                         hv};
      is_word: ld_val = rdata_r;
    endcase
  end

  assign mem_result = (load & ~err) ? ld_val : b.res;

  always_comb begin
    state_n = state;
    req     = 1'b0;
    unique case (state)
      IDLE: begin
        req = MEM_valid & memop & ~err & ~cancel;
        if (req & dm.dm_ack)
          state_n = DONE;
        else if (req)
          state_n = REQ;
      end
      REQ: begin
        req = 1'b1;
        if (dm.dm_ack & ~cancel)
          state_n = DONE;
        else if (dm.dm_ack)
          state_n = IDLE;
        else if (cancel)
          state_n = DRAIN;
      end
      DONE: begin
        if (MEM_WB_go | cancel)
          state_n = IDLE;
      end
      DRAIN: begin
        req = 1'b1;
        if (dm.dm_ack)
          state_n = IDLE;
      end
    endcase
  end

  assign dm.dm_req = req & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rdata_r <= 32'd0;
    end else begin
      state <= state_n;
      if (dm.dm_req & dm.dm_ack & load)
        rdata_r <= dm.dm_rdata;
    end
  end

  // A flushed request still owns memory until its ack drains.
  assign MEM_over = MEM_valid & ~cancel & ~reset
                  & (state != DRAIN)
                  & (~memop | err | (state == DONE));

  assign MEM_WB_bus = {
    mem_result, b.lo,
    b.hi_write, b.lo_write,
    b.mfhi, b.mflo,
    b.mtc0, b.mfc0,
    b.cp0r, b.syscall, b.eret,
    b.rf_wen & ~err, b.rf_wdest,
    b.pc, b.brk, adel, ades
  };

  assign MEM_wdest = b.rf_wdest & {5{MEM_valid}};
  assign MEM_pc    = b.pc;

endmodule

// File: tb/tb_mem.sv
// Directed self-checking bench for the mem stage.
// Expected values are hand-computed per step.
module tb_mem;
  logic         clk = 1'b0;
  logic         reset;
  logic         MEM_valid;
  logic [156:0] EXE_MEM_bus_r;
  logic         MEM_WB_go;
  logic         cancel;
  logic         MEM_over;
  logic [120:0] MEM_WB_bus;
  logic [4:0]   MEM_wdest;
  logic [31:0]  MEM_pc;

  int n_cmp = 0;
  int n_bad = 0;

  mem_if bus ();

  mem dut (
    .clk           (clk),
    .reset         (reset),
    .MEM_valid     (MEM_valid),
    .EXE_MEM_bus_r (EXE_MEM_bus_r),
    .MEM_WB_go     (MEM_WB_go),
    .cancel        (cancel),
    .dm            (bus),
    .MEM_over      (MEM_over),
    .MEM_WB_bus    (MEM_WB_bus),
    .MEM_wdest     (MEM_wdest),
    .MEM_pc        (MEM_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [156:0] mk(
    input logic [5:0]  mc,
    input logic [31:0] sd,
    input logic [31:0] ea,
    input logic [4:0]  wd,
    input logic [31:0] pc
  );
    return {mc, sd, ea, 32'h0, 6'b0, 8'h0,
            2'b00, 1'b1, wd, pc, 1'b0};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  localparam logic [5:0] ALU = 6'b000000;
  localparam logic [5:0] LB  = 6'b100010;
  localparam logic [5:0] LHU = 6'b100100;
  localparam logic [5:0] LW  = 6'b101000;
  localparam logic [5:0] SB  = 6'b010000;
  localparam logic [5:0] SH  = 6'b010100;

  logic [31:0] mres;

  assign mres = MEM_WB_bus[120:89];

  initial begin
    reset         = 1'b1;
    MEM_valid     = 1'b1;
    MEM_WB_go     = 1'b0;
    cancel        = 1'b0;
    bus.dm_ack    = 1'b0;
    bus.dm_rdata  = 32'h0;
    EXE_MEM_bus_r = mk(LW, 0, 32'h10, 5'd1, 32'h0);
    tick();
    smp();
    chk("rst_req", 32'(bus.dm_req), 0);
    chk("rst_over", 32'(MEM_over), 0);

    // ALU op completes in its own cycle
    tick();
    reset = 1'b0;
    EXE_MEM_bus_r = mk(ALU, 0, 32'h1234, 5'd7, 32'hBFC0_0010);
    smp();
    chk("alu_over", 32'(MEM_over), 1);
    chk("alu_req", 32'(bus.dm_req), 0);
    chk("alu_res", mres, 32'h1234);
    chk("alu_wdest", 32'(MEM_wdest), 7);
    chk("alu_pc", MEM_pc, 32'hBFC0_0010);
    MEM_WB_go = 1'b1;

    // LB signed, two wait states
    tick();
    MEM_WB_go = 1'b0;
    EXE_MEM_bus_r = mk(LB, 0, 32'h103, 5'd2, 32'h20);
    bus.dm_rdata = 32'h80FF_FF7F;
    smp();
    chk("lb_req0", 32'(bus.dm_req), 1);
    chk("lb_wr", 32'(bus.dm_wr), 0);
    chk("lb_addr", bus.dm_addr, 32'h100);
    chk("lb_strb", 32'(bus.dm_wstrb), 0);
    chk("lb_over0", 32'(MEM_over), 0);
    tick();
    smp();
    chk("lb_req1", 32'(bus.dm_req), 1);
    chk("lb_over1", 32'(MEM_over), 0);
    tick();
    bus.dm_ack = 1'b1;
    smp();
    chk("lb_req2", 32'(bus.dm_req), 1);
    chk("lb_over2", 32'(MEM_over), 0);
    tick();
    bus.dm_ack = 1'b0;
    bus.dm_rdata = 32'h0;
    smp();
    chk("lb_over3", 32'(MEM_over), 1);
    chk("lb_req3", 32'(bus.dm_req), 0);
    chk("lb_res", mres, 32'hFFFF_FF80);
    MEM_WB_go = 1'b1;

    // SH zero-wait, DONE held until go
    tick();
    MEM_WB_go = 1'b0;
    EXE_MEM_bus_r = mk(SH, 32'hAAAA_BEEF, 32'h202, 5'd0, 32'h24);
    bus.dm_ack = 1'b1;
    smp();
    chk("sh_req", 32'(bus.dm_req), 1);
    chk("sh_wr", 32'(bus.dm_wr), 1);
    chk("sh_addr", bus.dm_addr, 32'h200);
    chk("sh_strb", 32'(bus.dm_wstrb), 32'hC);
    chk("sh_wdata", bus.dm_wdata, 32'hBEEF_BEEF);
    chk("sh_over0", 32'(MEM_over), 0);
    tick();
    bus.dm_ack = 1'b0;
    smp();
    chk("sh_over1", 32'(MEM_over), 1);
    chk("sh_req1", 32'(bus.dm_req), 0);
    tick();
    smp();
    chk("sh_hold", 32'(MEM_over), 1);
    chk("sh_res", mres, 32'h202);
    MEM_WB_go = 1'b1;

    // SB lane and replication
    tick();
    MEM_WB_go = 1'b0;
    EXE_MEM_bus_r = mk(SB, 32'h1234_56A5, 32'h601, 5'd0, 32'h28);
    bus.dm_ack = 1'b1;
    smp();
    chk("sb_strb", 32'(bus.dm_wstrb), 32'h2);
    chk("sb_wdata", bus.dm_wdata, 32'hA5A5_A5A5);
    tick();
    bus.dm_ack = 1'b0;
    MEM_WB_go = 1'b1;
    smp();
    chk("sb_over", 32'(MEM_over), 1);

    // LHU upper half, zero extension
    tick();
    MEM_WB_go = 1'b0;
    EXE_MEM_bus_r = mk(LHU, 0, 32'h602, 5'd3, 32'h2C);
    bus.dm_ack = 1'b1;
    bus.dm_rdata = 32'h8001_7FFF;
    smp();
    chk("lhu_req", 32'(bus.dm_req), 1);
    tick();
    bus.dm_ack = 1'b0;
    bus.dm_rdata = 32'h0;
    MEM_WB_go = 1'b1;
    smp();
    chk("lhu_res", mres, 32'h0000_8001);

    // LW cancelled while waiting: drain
    tick();
    MEM_WB_go = 1'b0;
    EXE_MEM_bus_r = mk(LW, 0, 32'h400, 5'd4, 32'h30);
    smp();
    chk("cn_req0", 32'(bus.dm_req), 1);
    tick();
    cancel = 1'b1;
    smp();
    chk("cn_req1", 32'(bus.dm_req), 1);
    chk("cn_over1", 32'(MEM_over), 0);
    tick();
    cancel = 1'b0;
    smp();
    chk("cn_drain", 32'(bus.dm_req), 1);
    chk("cn_over2", 32'(MEM_over), 0);
    tick();
    bus.dm_ack = 1'b1;
    smp();
    chk("cn_req3", 32'(bus.dm_req), 1);
    chk("cn_over3", 32'(MEM_over), 0);
    tick();
    bus.dm_ack = 1'b0;
    EXE_MEM_bus_r = mk(ALU, 0, 32'h55, 5'd5, 32'h34);
    smp();
    chk("cn_idle", 32'(MEM_over), 1);
    chk("cn_req4", 32'(bus.dm_req), 0);

    // LW at misaligned address 0x301
    tick();
    EXE_MEM_bus_r = mk(LW, 0, 32'h301, 5'd6, 32'h38);
`ifdef MEM_ALIGN_CHECK_EN
    smp();
    chk("al_req", 32'(bus.dm_req), 0);
    chk("al_over", 32'(MEM_over), 1);
    chk("al_adel", 32'(MEM_WB_bus[1]), 1);
    chk("al_wen", 32'(MEM_WB_bus[40]), 0);
    chk("al_res", mres, 32'h301);
    MEM_WB_go = 1'b1;
`else
    bus.dm_ack = 1'b1;
    bus.dm_rdata = 32'h1122_3344;
    smp();
    chk("al_req", 32'(bus.dm_req), 1);
    chk("al_addr", bus.dm_addr, 32'h300);
    tick();
    bus.dm_ack = 1'b0;
    bus.dm_rdata = 32'h0;
    MEM_WB_go = 1'b1;
    smp();
    chk("al_over", 32'(MEM_over), 1);
    chk("al_adel", 32'(MEM_WB_bus[1]), 0);
    chk("al_wen", 32'(MEM_WB_bus[40]), 1);
    chk("al_res", mres, 32'h1122_3344);
`endif

    // Back-to-back zero-wait LW/LW
    tick();
    MEM_WB_go = 1'b0;
    EXE_MEM_bus_r = mk(LW, 0, 32'h500, 5'd8, 32'h3C);
    bus.dm_ack = 1'b1;
    bus.dm_rdata = 32'hCAFE_F00D;
    smp();
    chk("bb_req0", 32'(bus.dm_req), 1);
    tick();
    bus.dm_ack = 1'b0;
    bus.dm_rdata = 32'h0;
    MEM_WB_go = 1'b1;
    smp();
    chk("bb_over0", 32'(MEM_over), 1);
    chk("bb_res0", mres, 32'hCAFE_F00D);
    tick();
    MEM_WB_go = 1'b0;
    EXE_MEM_bus_r = mk(LW, 0, 32'h504, 5'd9, 32'h40);
    bus.dm_ack = 1'b1;
    bus.dm_rdata = 32'h0BAD_BEEF;
    smp();
    chk("bb_req1", 32'(bus.dm_req), 1);
    chk("bb_addr1", bus.dm_addr, 32'h504);
    tick();
    bus.dm_ack = 1'b0;
    bus.dm_rdata = 32'h0;
    MEM_WB_go = 1'b1;
    smp();
    chk("bb_over1", 32'(MEM_over), 1);
    chk("bb_res1", mres, 32'h0BAD_BEEF);

    // Reset while a request is outstanding
    tick();
    MEM_WB_go = 1'b0;
    EXE_MEM_bus_r = mk(LW, 0, 32'h700, 5'd10, 32'h44);
    tick();
    reset = 1'b1;
    smp();
    chk("rr_req", 32'(bus.dm_req), 0);
    tick();
    reset = 1'b0;
    EXE_MEM_bus_r = mk(ALU, 0, 32'h77, 5'd11, 32'h48);
    smp();
    chk("rr_idle", 32'(MEM_over), 1);
    chk("rr_res", mres, 32'h77);
    MEM_valid = 1'b0;
    #1;
    chk("nv_wdest", 32'(MEM_wdest), 0);
    chk("nv_over", 32'(MEM_over), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
